// File: rtl/ddr_package.sv
// Shared types and helpers for the DDR4 initialization sequencer.
//   cmd_t        : command encoding on cmd_type (NOP/MRS/ZQCL)
//   init_state_t : sequencer FSM states, exported on init_state for debug
//   MR_ORDER     : mode-register programming order (MR3,MR6,MR5,MR4,MR2,MR1,MR0)
//   cl_code      : CAS latency -> 4-bit MR0 CL code (CL9=0000 .. CL16=0111)
//   cwl_code     : CAS write latency -> 3-bit MR2 CWL code (CWL9=000 ..)
package ddr_package;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_MRS  = 2'd1,
    CMD_ZQCL = 2'd2
  } cmd_t;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_CKE_WAIT  = 3'd1,
    ST_MRS_ISSUE = 3'd2,
    ST_MRS_GAP   = 3'd3,
    ST_ZQ_ISSUE  = 3'd4,
    ST_ZQ_WAIT   = 3'd5,
    ST_DONE      = 3'd6
  } init_state_t;

  localparam int NUM_MRS = 7;
  localparam logic [2:0] LAST_MR_IDX = 3'd6;

  localparam logic [2:0] MR_ORDER [NUM_MRS] = '{3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};

  function automatic logic [3:0] cl_code(input int cl);
    return 4'(cl - 9);
  endfunction

  function automatic logic [2:0] cwl_code(input int cwl);
    return 3'(cwl - 9);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_delay_cnt.sv
// Loadable down-counter shared by every wait in the init sequencer.
//   clk_i      in  1  clock
//   rst_i      in  1  asynchronous active-high reset (count -> 0)
//   load_i     in  1  load load_val_i this cycle (has priority over counting)
//   load_val_i in  W  value to load
//   done_o     out 1  count is 1: the current cycle is the last one of the wait
//   idle_o     out 1  count is 0: nothing has been loaded yet / wait expired
// Loading N at the edge that enters a wait state makes done_o assert on the
// N-th edge spent in that state, so the state can leave exactly on time.
module ddr_delay_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o,
  output logic         idle_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));
  assign idle_o = (cnt_q == '0);

endmodule

// File: rtl/ddr_init_sequencer.sv
// DDR4 power-up / initialization sequencer.
// After reset: CKE low for RESET_HOLD cycles, CKE high, wait tXPR, program
// MR3,MR6,MR5,MR4,MR2,MR1,MR0 (tMRD apart, tMOD after MR0), issue ZQCL,
// wait tZQINIT, then hold init_done high until the next reset.
// Ports:
//   clock      in  1   controller clock
//   reset      in  1   asynchronous active-high reset
//   cmd_ready  in  1   downstream accepts the presented command this cycle
//   cke        out 1   DRAM clock enable
//   cmd_valid  out 1   command presented
//   cmd_type   out 2   cmd_t (NOP/MRS/ZQCL)
//   cmd_bank   out 3   MR number for MRS, 0 for ZQCL
//   cmd_addr   out 18  MR payload for MRS, A10=1 for ZQCL
//   init_done  out 1   sticky initialization-complete flag
//   init_state out 3   current FSM state (debug)
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_valid and all fields stay constant until that
// edge, and cmd_ready is ignored while cmd_valid is low.
module ddr_init_sequencer
  import ddr_package::*;
#(
  parameter int         tCAS_W       = 10,
  parameter int         tCAS_R       = 13,
  parameter logic [1:0] BURST_LENGTH = 2'b01,
  parameter logic [1:0] AL_DLY       = 2'b00,
  parameter int         RESET_HOLD   = 20,
  parameter int         tXPR         = 10,
  parameter int         tMRD         = 8,
  parameter int         tMOD         = 24,
  parameter int         tZQINIT      = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_ready,
  output logic        cke,
  output logic        cmd_valid,
  output logic [1:0]  cmd_type,
  output logic [2:0]  cmd_bank,
  output logic [17:0] cmd_addr,
  output logic        init_done,
  output logic [2:0]  init_state
);

  localparam int CNT_MAX = max_int(max_int(max_int(RESET_HOLD, tXPR), max_int(tMRD, tMOD)), tZQINIT);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  if (tCAS_W < 9 || tCAS_W > 12) begin : g_bad_cwl
    $error("ddr_init_sequencer: tCAS_W must be 9..12");
  end
  if (tCAS_R < 9 || tCAS_R > 16) begin : g_bad_cl
    $error("ddr_init_sequencer: tCAS_R must be 9..16");
  end
  // Waits load (N-1) after the entering edge, so every delay must be >= 2
  // (tXPR is loaded as-is and only needs >= 1).
  if (RESET_HOLD < 2 || tXPR < 1 || tMRD < 2 || tMOD < 2 || tZQINIT < 2) begin : g_bad_dly
    $error("ddr_init_sequencer: delay parameters out of range");
  end

  init_state_t      state_q, state_d;
  logic [2:0]       mr_idx_q, mr_idx_d;
  logic             mrs_done_q, mrs_done_d;   // MR0 has been transferred
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;
  logic             cnt_idle;
  logic [2:0]       mr_num;
  logic [17:0]      mr_payload;

  ddr_delay_cnt #(.W(CNT_W)) u_delay_cnt (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .done_o     (cnt_done),
    .idle_o     (cnt_idle)
  );

  always_comb begin
    state_d      = state_q;
    mr_idx_d     = mr_idx_q;
    mrs_done_d   = mrs_done_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_HOLD: begin
        // The counter is 0 only on the very first cycle after reset; that
        // cycle is the first of the hold, so load RESET_HOLD-1 for the rest.
        if (cnt_idle) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(RESET_HOLD - 1);
        end else if (cnt_done) begin
          state_d      = ST_CKE_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(tXPR);
        end
      end
      ST_CKE_WAIT: begin
        if (cnt_done) state_d = ST_MRS_ISSUE;
      end
      ST_MRS_ISSUE: begin
        if (cmd_ready) begin
          state_d  = ST_MRS_GAP;
          cnt_load = 1'b1;
          if (mr_idx_q == LAST_MR_IDX) begin
            mrs_done_d   = 1'b1;
            cnt_load_val = CNT_W'(tMOD - 1);
          end else begin
            mr_idx_d     = mr_idx_q + 3'd1;
            cnt_load_val = CNT_W'(tMRD - 1);
          end
        end
      end
      ST_MRS_GAP: begin
        if (cnt_done) state_d = mrs_done_q ? ST_ZQ_ISSUE : ST_MRS_ISSUE;
      end
      ST_ZQ_ISSUE: begin
        if (cmd_ready) begin
          state_d      = ST_ZQ_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(tZQINIT - 1);
        end
      end
      ST_ZQ_WAIT: begin
        if (cnt_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      mr_idx_q   <= 3'd0;
      mrs_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mr_idx_q   <= mr_idx_d;
      mrs_done_q <= mrs_done_d;
    end
  end

  // Mode-register payloads; bits not listed stay zero.
  assign mr_num = MR_ORDER[mr_idx_q];

  always_comb begin
    mr_payload = '0;
    case (mr_num)
      3'd0: begin
        mr_payload[1:0] = (BURST_LENGTH == 2'b10) ? 2'b10 : 2'b00;
        mr_payload[6]   = cl_code(tCAS_R)[3];
        mr_payload[5]   = cl_code(tCAS_R)[2];
        mr_payload[4]   = cl_code(tCAS_R)[1];
        mr_payload[2]   = cl_code(tCAS_R)[0];
      end
      3'd1: begin
        mr_payload[0]   = 1'b1;
        mr_payload[4:3] = AL_DLY;
      end
      3'd2: begin
        mr_payload[5:3] = cwl_code(tCAS_W);
      end
      default: begin
        mr_payload = '0;
      end
    endcase
  end

  // Outputs decode straight from registered state, so reset forces them
  // to their idle values without waiting for a clock edge.
  always_comb begin
    cke       = (state_q != ST_HOLD);
    cmd_valid = 1'b0;
    cmd_type  = CMD_NOP;
    cmd_bank  = 3'd0;
    cmd_addr  = 18'd0;
    init_done = (state_q == ST_DONE);
    case (state_q)
      ST_MRS_ISSUE: begin
        cmd_valid = 1'b1;
        cmd_type  = CMD_MRS;
        cmd_bank  = mr_num;
        cmd_addr  = mr_payload;
      end
      ST_ZQ_ISSUE: begin
        cmd_valid    = 1'b1;
        cmd_type     = CMD_ZQCL;
        cmd_addr[10] = 1'b1;
      end
      default: begin
        cmd_valid = 1'b0;
      end
    endcase
  end

  assign init_state = state_q;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Bench for ddr_init_sequencer. Cycle c is the c-th rising edge after reset
// release; the value "at cycle c" is what that edge samples, observed at the
// preceding falling edge.
module tb_ddr_init_sequencer;

  localparam int RESET_HOLD = 20;
  localparam int TXPR       = 10;
  localparam int TMRD       = 8;
  localparam int TMOD       = 24;
  localparam int TZQ        = 64;
  localparam int MAXC       = 700;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_ready = 1'b0;
  logic ready5 = 1'b1;
  always #5 clock = ~clock;

  logic        cke, cmd_valid, init_done;
  logic [1:0]  cmd_type;
  logic [2:0]  cmd_bank, init_state;
  logic [17:0] cmd_addr;

  logic        p_cke, p_valid, p_done;
  logic [1:0]  p_type;
  logic [2:0]  p_bank, p_state;
  logic [17:0] p_addr;

  ddr_init_sequencer dut (
    .clock(clock), .reset(reset), .cmd_ready(cmd_ready),
    .cke(cke), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
    .cmd_addr(cmd_addr), .init_done(init_done), .init_state(init_state)
  );

  ddr_init_sequencer #(.tCAS_R(16), .BURST_LENGTH(2'b10), .AL_DLY(2'b01)) dut5 (
    .clock(clock), .reset(reset), .cmd_ready(ready5),
    .cke(p_cke), .cmd_valid(p_valid), .cmd_type(p_type), .cmd_bank(p_bank),
    .cmd_addr(p_addr), .init_done(p_done), .init_state(p_state)
  );

  int total = 0;
  int bad = 0;

  logic ready_arr [MAXC];
  logic exp_valid_a [MAXC];
  logic obs_valid [MAXC];
  logic obs_cke [MAXC];
  logic obs_done [MAXC];
  int   exp_x_cyc [8];
  int   exp_done_cyc;

  int          act_cyc [$];
  logic [2:0]  act_bank [$];
  logic [1:0]  act_type [$];
  logic [17:0] act_addr [$];
  int          stall_err;
  logic [17:0] p_mr_addr [8];

  // ---------------- reference model ----------------
  function automatic logic [17:0] mr_payload(input int mr, input logic [1:0] bl, input int cl,
                                             input int cwl, input logic [1:0] al);
    int v;
    int code;
    v = 0;
    code = cl - 9;
    case (mr)
      0: begin
        v = (bl == 2'b10) ? 2 : 0;
        v += ((code >> 3) & 1) * 64 + ((code >> 2) & 1) * 32 + ((code >> 1) & 1) * 16 + (code & 1) * 4;
      end
      1: v = 1 + int'(al) * 8;
      2: v = (cwl - 9) * 8;
      default: v = 0;
    endcase
    return 18'(v);
  endfunction

  function automatic int bank_of(input int i);
    int order [8];
    order = '{3, 6, 5, 4, 2, 1, 0, 0};
    return order[i];
  endfunction

  // Command i (0..6 MRS, 7 ZQCL) becomes valid at its start cycle and
  // transfers at the first cycle from there on with ready high.
  task automatic model_schedule();
    int t;
    int c;
    for (int k = 0; k < MAXC; k++) exp_valid_a[k] = 1'b0;
    t = RESET_HOLD + TXPR;
    for (int i = 0; i < 8; i++) begin
      c = t;
      while (c < MAXC - 1 && !ready_arr[c]) c++;
      exp_x_cyc[i] = c;
      for (int k = t; k <= c; k++) exp_valid_a[k] = 1'b1;
      t = c + ((i == 6) ? TMOD : TMRD);
    end
    exp_done_cyc = exp_x_cyc[7] + TZQ;
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    reset = 1'b1;
    cmd_ready = 1'b0;
    for (int m = 0; m < 8; m++) p_mr_addr[m] = 18'h3ffff;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    logic hold_prev;
    logic [1:0] tp;
    logic [2:0] bp;
    logic [17:0] ap;
    hold_prev = 1'b0;
    tp = '0; bp = '0; ap = '0;
    act_cyc.delete(); act_bank.delete(); act_type.delete(); act_addr.delete();
    stall_err = 0;
    for (int c = 0; c < n; c++) begin
      cmd_ready = ready_arr[c];
      #1;
      obs_valid[c] = cmd_valid;
      obs_cke[c]   = cke;
      obs_done[c]  = init_done;
      if (hold_prev && (cmd_valid !== 1'b1 || cmd_type !== tp || cmd_bank !== bp || cmd_addr !== ap))
        stall_err++;
      hold_prev = cmd_valid && !cmd_ready;
      tp = cmd_type; bp = cmd_bank; ap = cmd_addr;
      if (cmd_valid && cmd_ready) begin
        act_cyc.push_back(c);
        act_bank.push_back(cmd_bank);
        act_type.push_back(cmd_type);
        act_addr.push_back(cmd_addr);
      end
      if (p_valid && p_type == 2'd1) p_mr_addr[p_bank] = p_addr;
      @(negedge clock);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    total++;
    if ({cke, cmd_valid, cmd_type, cmd_bank, cmd_addr, init_done, init_state} !== 28'd0) begin
      bad++;
      $display("FAIL reset_values: got cke=%b valid=%b type=%0d bank=%0d addr=%h done=%b state=%0d, want all zero",
               cke, cmd_valid, cmd_type, cmd_bank, cmd_addr, init_done, init_state);
    end
  endtask

  // mode 0: ready always high, 1: ready low on cycles 46..50, 2: random ready
  task automatic test_sequence(input string tag, input int mode, input int cut);
    int n;
    int nexp;
    int first_done;
    int cke_bad, valid_bad, done_bad;
    int ec, eb, et;
    logic [17:0] ea;
    for (int c = 0; c < MAXC; c++) begin
      if (mode == 2) ready_arr[c] = ($urandom_range(0, 3) != 0);
      else           ready_arr[c] = !(mode == 1 && c >= 46 && c <= 50);
    end
    model_schedule();
    n = (cut > 0) ? cut : exp_done_cyc + 6;
    if (n > MAXC) n = MAXC;
    do_reset();
    run_cycles(n);

    nexp = 0;
    for (int i = 0; i < 8; i++) if (exp_x_cyc[i] < n) nexp++;
    total++;
    if (act_cyc.size() !== nexp) begin
      bad++;
      $display("FAIL %s xfer_count: got %0d, want %0d", tag, act_cyc.size(), nexp);
    end
    for (int i = 0; i < nexp && i < act_cyc.size(); i++) begin
      ec = exp_x_cyc[i];
      eb = (i < 7) ? bank_of(i) : 0;
      et = (i < 7) ? 1 : 2;
      ea = (i < 7) ? mr_payload(bank_of(i), 2'b01, 13, 10, 2'b00) : 18'h00400;
      total++;
      if (act_cyc[i] !== ec || act_bank[i] !== 3'(eb) || act_type[i] !== 2'(et) || act_addr[i] !== ea) begin
        bad++;
        $display("FAIL %s xfer%0d: got cyc=%0d bank=%0d type=%0d addr=%h, want cyc=%0d bank=%0d type=%0d addr=%h",
                 tag, i, act_cyc[i], act_bank[i], act_type[i], act_addr[i], ec, eb, et, ea);
      end
    end

    cke_bad = 0; valid_bad = 0; done_bad = 0; first_done = -1;
    for (int c = 0; c < n; c++) begin
      if (obs_cke[c] !== (c >= RESET_HOLD)) cke_bad++;
      if (obs_valid[c] !== exp_valid_a[c]) valid_bad++;
      if (obs_done[c] !== (c >= exp_done_cyc)) done_bad++;
      if (obs_done[c] === 1'b1 && first_done < 0) first_done = c;
    end
    total++;
    if (cke_bad != 0) begin
      bad++;
      $display("FAIL %s cke_profile: got %0d wrong cycles, want 0 (rise at %0d)", tag, cke_bad, RESET_HOLD);
    end
    total++;
    if (valid_bad != 0) begin
      bad++;
      $display("FAIL %s valid_profile: got %0d wrong cycles, want 0", tag, valid_bad);
    end
    total++;
    if (done_bad != 0) begin
      bad++;
      $display("FAIL %s done_profile: got %0d wrong cycles (first high %0d), want 0 (first high %0d)",
               tag, done_bad, first_done, exp_done_cyc);
    end
    total++;
    if (stall_err != 0) begin
      bad++;
      $display("FAIL %s stall_hold: got %0d field changes while stalled, want 0", tag, stall_err);
    end
    if (mode == 0 && cut == 0) begin
      total++;
      if (first_done !== 166) begin
        bad++;
        $display("FAIL %s done_cycle: got %0d, want 166", tag, first_done);
      end
    end
    if (mode == 1) begin
      ec = (act_cyc.size() > 3) ? act_cyc[2] : -1;
      eb = (act_cyc.size() > 3) ? act_cyc[3] : -1;
      total++;
      if (ec !== 51 || eb !== 59) begin
        bad++;
        $display("FAIL %s mr5_mr4_cycles: got %0d,%0d, want 51,59", tag, ec, eb);
      end
    end
  endtask

  task automatic test_params();
    logic [17:0] e;
    for (int mr = 0; mr < 4; mr++) begin
      e = mr_payload(mr, 2'b10, 16, 10, 2'b01);
      total++;
      if (p_mr_addr[mr] !== e) begin
        bad++;
        $display("FAIL params_mr%0d: got %h, want %h", mr, p_mr_addr[mr], e);
      end
    end
  endtask

  task automatic test_done_ready();
    for (int c = 0; c < 24; c++) begin
      cmd_ready = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (cmd_valid !== 1'b0 || init_done !== 1'b1 || cke !== 1'b1 || init_state !== 3'd6) begin
        bad++;
        $display("FAIL done_ready%0d: got valid=%b done=%b cke=%b state=%0d, want 0 1 1 6",
                 c, cmd_valid, init_done, cke, init_state);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid();
    test_sequence("pre_reset", 0, 60);
    total++;
    if (obs_cke[59] !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_cke: got %b, want 1", obs_cke[59]);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({cke, cmd_valid, cmd_type, cmd_bank, cmd_addr, init_done, init_state} !== 28'd0) begin
      bad++;
      $display("FAIL mid_reset_values: got cke=%b valid=%b type=%0d bank=%0d addr=%h done=%b state=%0d, want all zero",
               cke, cmd_valid, cmd_type, cmd_bank, cmd_addr, init_done, init_state);
    end
    test_sequence("after_reset", 0, 0);
  endtask

  initial begin
    test_reset();
    test_sequence("defaults", 0, 0);
    test_params();
    test_done_ready();
    test_sequence("stall", 1, 0);
    test_sequence("random1", 2, 0);
    test_sequence("random2", 2, 0);
    test_sequence("random3", 2, 0);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
